// File: rtl/fp_to_int_if.sv
// rtl/fp_to_int_if.sv - request/result bundle between a requester and fp_to_int
interface fp_to_int_if;
    logic        start;
    logic [31:0] op_in;
    logic [31:0] data_out;
    logic [3:0]  status_out;
    logic        busy;
    logic        done;

    modport slave (
        input  start,
        input  op_in,
        output data_out,
        output status_out,
        output busy,
        output done
    );

    modport master (
        output start,
        output op_in,
        input  data_out,
        input  status_out,
        input  busy,
        input  done
    );
endinterface

// File: rtl/fp_to_int.sv
// rtl/fp_to_int.sv - multi-cycle custom float (6-bit exp, bias 31) to int32 converter
module fp_to_int (
    input  logic         clock100KHz,
    input  logic         reset,
    fp_to_int_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UNPACK = 2'd1,
        SHIFT  = 2'd2,
        PACK   = 2'd3
    } state_t;

    localparam logic [3:0] ST_EXACT     = 4'b0001;
    localparam logic [3:0] ST_INEXACT   = 4'b0010;
    localparam logic [3:0] ST_OVERFLOW  = 4'b0100;
    localparam logic [3:0] ST_UNDERFLOW = 4'b1000;

    state_t      r_state;
    logic [31:0] r_op;
    logic [31:0] r_mag;
    logic [4:0]  r_cnt;
    logic        r_sticky;
    logic        r_left;
    logic        r_special;
    logic [3:0]  r_spec_status;
    logic [31:0] r_data_out;
    logic [3:0]  r_status_out;
    logic        r_busy;
    logic        r_done;

    logic        w_sign;
    logic [5:0]  w_exp;
    logic [24:0] w_mant;
    logic [25:0] w_sig;
    logic [4:0]  w_right_n;
    logic [4:0]  w_left_n;

    assign w_sign = r_op[31];
    assign w_exp  = r_op[30:25];
    assign w_mant = r_op[24:0];
    assign w_sig  = {1'b1, w_mant};
    // Shift amounts are < 32, so modulo-32 arithmetic on exp[4:0] is exact.
    assign w_right_n = 5'd24 - w_exp[4:0];
    assign w_left_n  = w_exp[4:0] - 5'd24;

    always_ff @(posedge clock100KHz) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_op          <= 32'd0;
            r_mag         <= 32'd0;
            r_cnt         <= 5'd0;
            r_sticky      <= 1'b0;
            r_left        <= 1'b0;
            r_special     <= 1'b0;
            r_spec_status <= 4'd0;
            r_data_out    <= 32'd0;
            r_status_out  <= 4'd0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_op      <= bus.op_in;
                        r_sticky  <= 1'b0;
                        r_special <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= UNPACK;
                    end
                end

                UNPACK: begin
                    r_mag <= {6'd0, w_sig};
                    if (w_exp == 6'd0 && w_mant == 25'd0) begin
                        r_special     <= 1'b1;
                        r_spec_status <= ST_EXACT;
                        r_mag         <= 32'd0;
                        r_state       <= PACK;
                    end else if (w_exp <= 6'd30) begin
                        r_special     <= 1'b1;
                        r_spec_status <= ST_UNDERFLOW;
                        r_mag         <= 32'd0;
                        r_state       <= PACK;
                    end else if (w_exp == 6'd62 && w_sign && w_mant == 25'd0) begin
                        r_special     <= 1'b1;
                        r_spec_status <= ST_EXACT;
                        r_mag         <= 32'h8000_0000;
                        r_state       <= PACK;
                    end else if (w_exp >= 6'd62) begin
                        r_special     <= 1'b1;
                        r_spec_status <= ST_OVERFLOW;
                        r_mag         <= 32'd0;
                        r_state       <= PACK;
                    end else if (w_exp == 6'd56) begin
                        r_state <= PACK;
                    end else if (w_exp < 6'd56) begin
                        r_left  <= 1'b0;
                        r_cnt   <= w_right_n;
                        r_state <= SHIFT;
                    end else begin
                        r_left  <= 1'b1;
                        r_cnt   <= w_left_n;
                        r_state <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (r_left) begin
                        r_mag <= {r_mag[30:0], 1'b0};
                    end else begin
                        r_mag <= {1'b0, r_mag[31:1]};
                        if (r_mag[0]) begin
                            r_sticky <= 1'b1;
                        end
                    end
                    r_cnt <= r_cnt - 5'd1;
                    if (r_cnt == 5'd1) begin
                        r_state <= PACK;
                    end
                end

                PACK: begin
                    if (r_special) begin
                        r_data_out   <= r_mag;
                        r_status_out <= r_spec_status;
                    end else begin
                        r_data_out   <= w_sign ? (~r_mag + 32'd1) : r_mag;
                        r_status_out <= r_sticky ? ST_INEXACT : ST_EXACT;
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.data_out   = r_data_out;
    assign bus.status_out = r_status_out;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
endmodule

// File: tb/tb_fp_to_int.sv
// tb/tb_fp_to_int.sv - directed vector bench for fp_to_int
module tb_fp_to_int;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fails;

    fp_to_int_if bus();

    fp_to_int dut (
        .clock100KHz (clk),
        .reset       (rst_n),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] op;
        logic [31:0] data;
        logic [3:0]  status;
        int          lat;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Start an operation; optionally inject a spurious start at cycle glitch.
    task automatic run_op(input logic [31:0] op, input int glitch,
                          output logic [31:0] data, output logic [3:0] status,
                          output int lat, output logic busy1);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op_in = op;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        busy1 = bus.busy;
        lat = 0;
        while (lat < 100) begin
            @(posedge clk);
            lat++;
            #1;
            bus.start = 1'b0;
            if (lat == glitch) begin
                bus.start = 1'b1;
                bus.op_in = 32'h7C00_0000;
            end
            if (bus.done) break;
        end
        data   = bus.data_out;
        status = bus.status_out;
        bus.op_in = 32'h0;
    endtask

    initial begin
        logic [31:0] d;
        logic [3:0]  s;
        int          lat;
        logic        b1;

        n_checks = 0;
        n_fails  = 0;
        bus.start = 1'b0;
        bus.op_in = 32'h0;
        rst_n = 1'b0;

        vecs[0]  = '{32'h3E00_0000, 32'h0000_0001, 4'b0001, 27};
        vecs[1]  = '{32'hC080_0000, 32'hFFFF_FFFE, 4'b0010, 26};
        vecs[2]  = '{32'h7BFF_FFFF, 32'h7FFF_FFE0, 4'b0001, 7};
        vecs[3]  = '{32'hFC00_0000, 32'h8000_0000, 4'b0001, 2};
        vecs[4]  = '{32'h7C00_0000, 32'h0000_0000, 4'b0100, 2};
        vecs[5]  = '{32'h3C00_0000, 32'h0000_0000, 4'b1000, 2};
        vecs[6]  = '{32'h8000_0000, 32'h0000_0000, 4'b0001, 2};
        vecs[7]  = '{32'h7000_0000, 32'h0200_0000, 4'b0001, 2};
        vecs[8]  = '{32'hF000_0000, 32'hFE00_0000, 4'b0001, 2};
        vecs[9]  = '{32'h6E00_0000, 32'h0100_0000, 4'b0001, 3};
        vecs[10] = '{32'h0000_0001, 32'h0000_0000, 4'b1000, 2};
        vecs[11] = '{32'h7E00_0000, 32'h0000_0000, 4'b0100, 2};
        vecs[12] = '{32'hFC00_0001, 32'h0000_0000, 4'b0100, 2};
        vecs[13] = '{32'h3F00_0000, 32'h0000_0001, 4'b0010, 27};
        vecs[14] = '{32'hBE00_0000, 32'hFFFF_FFFF, 4'b0001, 27};
        vecs[15] = '{32'h7200_0000, 32'h0400_0000, 4'b0001, 3};

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy",   {31'd0, bus.busy}, 32'd0);
        check("reset_done",   {31'd0, bus.done}, 32'd0);
        check("reset_data",   bus.data_out, 32'd0);
        check("reset_status", {28'd0, bus.status_out}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            run_op(vecs[i].op, 0, d, s, lat, b1);
            check($sformatf("v%0d_data", i), d, vecs[i].data);
            check($sformatf("v%0d_status", i), {28'd0, s}, {28'd0, vecs[i].status});
            check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("v%0d_busy", i), {31'd0, b1}, 32'd1);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_done_pulse", i), {31'd0, bus.done}, 32'd0);
        end

        // Spurious start mid-operation must not disturb the running conversion.
        run_op(32'h3E00_0000, 5, d, s, lat, b1);
        check("ignore_start_data",    d, 32'h0000_0001);
        check("ignore_start_status",  {28'd0, s}, 32'd1);
        check("ignore_start_latency", lat, 27);

        // Back-to-back: new start sampled in the done cycle.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op_in = 32'h7000_0000;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = 0;
        while (lat < 100 && !bus.done) begin
            @(posedge clk);
            lat++;
            #1;
        end
        check("b2b_first_latency", lat, 2);
        bus.start = 1'b1;
        bus.op_in = 32'hF000_0000;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("b2b_busy", {31'd0, bus.busy}, 32'd1);
        lat = 0;
        while (lat < 100) begin
            @(posedge clk);
            lat++;
            #1;
            if (bus.done) break;
        end
        check("b2b_second_latency", lat, 2);
        check("b2b_second_data", bus.data_out, 32'hFE00_0000);

        // Reset during SHIFT clears everything on the next edge.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op_in = 32'hC080_0000;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midreset_busy",   {31'd0, bus.busy}, 32'd0);
        check("midreset_done",   {31'd0, bus.done}, 32'd0);
        check("midreset_data",   bus.data_out, 32'd0);
        check("midreset_status", {28'd0, bus.status_out}, 32'd0);
        rst_n = 1'b1;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                check("midreset_no_late_done", 32'd1, 32'd0);
            end
        end

        run_op(32'hC080_0000, 0, d, s, lat, b1);
        check("post_reset_data",    d, 32'hFFFF_FFFE);
        check("post_reset_status",  {28'd0, s}, 32'd2);
        check("post_reset_latency", lat, 26);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/fp_to_int.md
FP_TO_INT -- requirements
Module: fp_to_int

Interface
REQ-001 SHALL have ports: clock100KHz  in  1  single clock, all state updates on rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-low; sampled only on the rising edge of clock100KHz.
REQ-003 SHALL have ports: start  in  1  request; sampled only in IDLE.
REQ-004 SHALL have ports: op_in  in  32  float operand: [31] sign, [30:25] exponent (bias 31), [24:0] mantissa; implicit 1 when exponent != 0.
REQ-005 SHALL have ports: data_out  out  32  two's-complement integer result, held until the next completion.
REQ-006 SHALL have ports: status_out  out  4  one-hot: 0001 exact, 0010 inexact, 0100 overflow, 1000 underflow; held like data_out.
REQ-007 SHALL have ports: busy  out  1  high in UNPACK, SHIFT and PACK.
REQ-008 SHALL have ports: done  out  1  registered one-cycle pulse; data_out/status_out valid from that cycle.

Function
REQ-009 SHALL compute value = (-1)^s * sig * 2^(exp-56), with sig = {implicit, mant[24:0]} (26 bits), and truncate toward zero.
REQ-010 SHALL implement states IDLE, UNPACK, SHIFT, PACK.
REQ-011 IDLE: on start=1, latch op_in and go to UNPACK; start=0 stays in IDLE.
REQ-012 start SHALL be ignored outside IDLE; the latched operand SHALL NOT change mid-operation.
REQ-013 UNPACK: classify the operand per REQ-014..REQ-018, then go to PACK (special cases, or exp=56) or SHIFT.
REQ-014 exp=0 and mant=0 (either sign): result 0, status 0001.
REQ-015 exp=0 with mant!=0, or 1<=exp<=30: result 0, status 1000.
REQ-016 exp=62, s=1, mant=0: result 0x80000000, status 0001.
REQ-017 any other exp>=62: result 0, status 0100.
REQ-018 31<=exp<=55 SHALL right-shift by n=56-exp (1..25); 57<=exp<=61 SHALL left-shift by n=exp-56 (1..5); exp=56 SHALL use n=0.
REQ-019 SHIFT: one bit per cycle into a 32-bit magnitude register; count decrements; go to PACK after the n-th shift.
REQ-020 Every 1 shifted out on the right SHALL set a sticky bit; a left shift SHALL never lose bits (max magnitude 0x7FFFFFE0).
REQ-021 PACK: negate the magnitude if s=1; register data_out, status_out (0010 if sticky, else 0001) and done=1; return to IDLE.
REQ-022 Latency from the start-sampling edge to the done-high edge SHALL be n+2 cycles, where n=0 for the special cases.
REQ-023 A new start MAY be sampled in the same cycle done is high.
REQ-024 status_out SHALL carry exactly one set bit after the first completion.

Reset
REQ-025 reset=0 at a rising edge SHALL force IDLE and clear busy, done, data_out, status_out, the shift count, the sticky bit and all internal registers, even mid-operation.
REQ-026 The first start after reset is released SHALL behave as from a fresh IDLE; no partial result from an aborted operation SHALL appear.

Verification
REQ-027 op_in=0x3E000000 (1.0) -> done 27 cycles after start, data_out 0x00000001, status 0001.
REQ-028 op_in=0xC0800000 (-2.5) -> done after 26 cycles, data_out 0xFFFFFFFE, status 0010.
REQ-029 op_in=0x7BFFFFFF -> done after 7 cycles, data_out 0x7FFFFFE0, status 0001.
REQ-030 op_in=0xFC000000 -> 0x80000000/0001 after 2 cycles; op_in=0x7C000000 -> 0x00000000/0100 after 2 cycles.
REQ-031 op_in=0x3C000000 (0.5) -> 0x00000000/1000; op_in=0x80000000 -> 0x00000000/0001; both after 2 cycles.
REQ-032 Start during busy -> ignored, and the original result completes unchanged; reset=0 during SHIFT -> next cycle busy=0, done=0, data_out=0, status_out=0.
